// File: rtl/rv_structs.sv
// Shared execute-stage types: ALU control one-hot, result group, writeback source,
// shift kinds and branch funct3 codes.
package rv_structs;

  typedef enum logic [1:0] {
    RES_ARITH = 2'd0,
    RES_LOGIC = 2'd1,
    RES_SHIFT = 2'd2,
    RES_CMP   = 2'd3
  } alu_res_t;

  typedef struct packed {
    logic add;
    logic sub;
    logic land;
    logic lor;
    logic lxor;
    logic sll;
    logic srl;
    logic sra;
    logic slt;
    logic sltu;
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MEM = 2'd1,
    SRC_CSR = 2'd2,
    SRC_PC4 = 2'd3
  } res_src_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_kind_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam alu_ctrl_t CTRL_NONE = '{default: 1'b0};
  localparam alu_ctrl_t CTRL_ADD  = '{add:  1'b1, default: 1'b0};
  localparam alu_ctrl_t CTRL_SUB  = '{sub:  1'b1, default: 1'b0};
  localparam alu_ctrl_t CTRL_AND  = '{land: 1'b1, default: 1'b0};
  localparam alu_ctrl_t CTRL_OR   = '{lor:  1'b1, default: 1'b0};
  localparam alu_ctrl_t CTRL_XOR  = '{lxor: 1'b1, default: 1'b0};
  localparam alu_ctrl_t CTRL_SLL  = '{sll:  1'b1, default: 1'b0};
  localparam alu_ctrl_t CTRL_SRL  = '{srl:  1'b1, default: 1'b0};
  localparam alu_ctrl_t CTRL_SRA  = '{sra:  1'b1, default: 1'b0};
  localparam alu_ctrl_t CTRL_SLT  = '{slt:  1'b1, default: 1'b0};
  localparam alu_ctrl_t CTRL_SLTU = '{sltu: 1'b1, default: 1'b0};

  function automatic shift_kind_t shift_kind(input alu_ctrl_t c);
    if (c.sra)      return SH_SRA;
    else if (c.srl) return SH_SRL;
    else            return SH_SLL;
  endfunction

endpackage

// File: rtl/rv_alu2_shifter.sv
// Shift unit for rv_alu2: single-cycle barrel shifter by default, or a 1-bit/cycle
// serial shifter with an IDLE/SHIFT FSM when ALU_SERIAL_SHIFT_EN is defined.
module rv_alu2_shifter
  import rv_structs::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_flush,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic [4:0]  i_load_amt,
  input  logic [31:0] i_val,
  input  logic [4:0]  i_amt,
  input  shift_kind_t i_kind,
  output logic [31:0] o_result,
  output logic        o_busy
);

`ifdef ALU_SERIAL_SHIFT_EN

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] acc;
  logic        unused_ok;

  assign unused_ok = ^i_amt;
  assign o_busy    = (state == SHIFT) && (cnt != 5'd0);
  // A zero shift never enters SHIFT, so the unshifted operand is the answer.
  assign o_result  = (state == SHIFT) ? acc : i_val;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_flush) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else if (o_busy) begin
      cnt <= cnt - 5'd1;
      case (i_kind)
        SH_SRL:  acc <= {1'b0, acc[31:1]};
        SH_SRA:  acc <= {acc[31], acc[31:1]};
        default: acc <= {acc[30:0], 1'b0};
      endcase
    end else if (i_load) begin
      state <= SHIFT;
      cnt   <= i_load_amt;
      acc   <= i_load_val;
    end else begin
      state <= IDLE;
    end
  end

`else

  logic unused_ok;

  assign unused_ok = ^{i_clk, i_reset_n, i_flush, i_load, i_load_val, i_load_amt};
  assign o_busy    = 1'b0;

  always_comb begin
    o_result = i_val;
    case (i_kind)
      SH_SLL:  o_result = i_val << i_amt;
      SH_SRL:  o_result = i_val >> i_amt;
      SH_SRA:  o_result = $unsigned($signed(i_val) >>> i_amt);
      default: o_result = i_val;
    endcase
  end

`endif

endmodule

// File: rtl/rv_alu2.sv
// Execute stage: registers operands/control, computes the ALU result and resolves branches
// against the fetch prediction. ALU_SERIAL_SHIFT_EN selects the serial (stalling) shifter.
module rv_alu2
  import rv_structs::*;
#(
  parameter int IADDR_SPACE_BITS = 32
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_flush,
  input  logic [31:0]                 i_op1,
  input  logic [31:0]                 i_op2,
  input  alu_res_t                    i_res,
  input  alu_ctrl_t                   i_ctrl,
  input  logic [2:0]                  i_funct3,
  input  res_src_t                    i_res_src,
  input  logic                        i_reg_write,
  input  logic [4:0]                  i_rd,
  input  logic                        i_store,
  input  logic                        i_inst_jal_jalr,
  input  logic                        i_inst_branch,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc_next,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc_target,
  input  logic                        i_branch_pred,
  input  logic [31:0]                 i_reg_data2,
  input  logic                        i_to_trap,
  output logic [31:0]                 o_result,
  output logic [31:0]                 o_store_data,
  output logic [4:0]                  o_rd,
  output logic                        o_reg_write,
  output res_src_t                    o_res_src,
  output logic [2:0]                  o_funct3,
  output logic                        o_store,
  output logic                        o_to_trap,
  output logic                        o_pc_select,
  output logic [IADDR_SPACE_BITS-1:0] o_pc_target,
  output logic                        o_stall
);

  logic                        stall;
  logic [31:0]                 op1_q, op2_q, store_data_q;
  alu_ctrl_t                   ctrl_q;
  alu_res_t                    res_q;
  logic [2:0]                  funct3_q;
  logic [IADDR_SPACE_BITS-1:0] pc_next_q, pc_target_q;
  logic [4:0]                  rd_q;
  logic                        reg_write_q, store_q, branch_q, jal_jalr_q, pred_q, to_trap_q;
  res_src_t                    res_src_q;
  logic [31:0]                 shift_result, alu_result, sum, diff;
  logic                        eq, lt, ltu, cond, taken;
  logic                        unused_pc;

  // The current pc itself is not needed once pc_next/pc_target are known.
  assign unused_pc = ^i_pc;

  always_ff @(posedge i_clk) begin
    if (!stall) begin
      op1_q        <= i_op1;
      op2_q        <= i_op2;
      ctrl_q       <= i_ctrl;
      res_q        <= i_res;
      funct3_q     <= i_funct3;
      pc_next_q    <= i_pc_next;
      pc_target_q  <= i_pc_target;
      store_data_q <= i_reg_data2;
    end
  end

  // Control is cleared by reset or flush even mid-stall, turning the stage into a bubble.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_flush) begin
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      store_q     <= 1'b0;
      branch_q    <= 1'b0;
      jal_jalr_q  <= 1'b0;
      pred_q      <= 1'b0;
      to_trap_q   <= 1'b0;
      res_src_q   <= SRC_ALU;
    end else if (!stall) begin
      rd_q        <= i_rd;
      reg_write_q <= i_reg_write;
      store_q     <= i_store;
      branch_q    <= i_inst_branch;
      jal_jalr_q  <= i_inst_jal_jalr;
      pred_q      <= i_branch_pred;
      to_trap_q   <= i_to_trap;
      res_src_q   <= i_res_src;
    end
  end

  rv_alu2_shifter u_shifter (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_flush    (i_flush),
    .i_load     ((i_res == RES_SHIFT) && (i_op2[4:0] != 5'd0)),
    .i_load_val (i_op1),
    .i_load_amt (i_op2[4:0]),
    .i_val      (op1_q),
    .i_amt      (op2_q[4:0]),
    .i_kind     (shift_kind(ctrl_q)),
    .o_result   (shift_result),
    .o_busy     (stall)
  );

  assign sum  = op1_q + op2_q;
  assign diff = op1_q - op2_q;
  assign eq   = (op1_q == op2_q);
  assign lt   = ($signed(op1_q) < $signed(op2_q));
  assign ltu  = (op1_q < op2_q);

  always_comb begin
    alu_result = '0;
    case (res_q)
      RES_ARITH: begin
        if (ctrl_q.sub)      alu_result = diff;
        else if (ctrl_q.add) alu_result = sum;
      end
      RES_LOGIC: begin
        if (ctrl_q.land)      alu_result = op1_q & op2_q;
        else if (ctrl_q.lor)  alu_result = op1_q | op2_q;
        else if (ctrl_q.lxor) alu_result = op1_q ^ op2_q;
      end
      RES_SHIFT: alu_result = shift_result;
      RES_CMP: begin
        if (ctrl_q.slt)       alu_result = {31'b0, lt};
        else if (ctrl_q.sltu) alu_result = {31'b0, ltu};
      end
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (funct3_q)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = !lt;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = !ltu;
      default: cond = 1'b0;
    endcase
  end

  assign taken = jal_jalr_q | (branch_q & cond);

  assign o_result     = jal_jalr_q ? 32'(pc_next_q) : alu_result;
  assign o_store_data = store_data_q;
  assign o_rd         = rd_q;
  assign o_res_src    = res_src_q;
  assign o_funct3     = funct3_q;
  assign o_to_trap    = to_trap_q;
  assign o_reg_write  = reg_write_q & !stall;
  assign o_store      = store_q & !stall;
  assign o_pc_select  = (branch_q | jal_jalr_q) & (taken != pred_q) & !stall;
  assign o_pc_target  = taken ? pc_target_q : pc_next_q;
  assign o_stall      = stall;

endmodule

// File: tb/tb_rv_alu2.sv
// Directed self-checking bench for rv_alu2; shift expectations follow ALU_SERIAL_SHIFT_EN.
module tb_rv_alu2;
  import rv_structs::*;

  localparam int AW = 32;

  logic          i_clk = 1'b0;
  logic          i_reset_n, i_flush;
  logic [31:0]   i_op1, i_op2, i_reg_data2;
  alu_res_t      i_res;
  alu_ctrl_t     i_ctrl;
  logic [2:0]    i_funct3;
  res_src_t      i_res_src;
  logic          i_reg_write, i_store, i_inst_jal_jalr, i_inst_branch, i_branch_pred, i_to_trap;
  logic [4:0]    i_rd;
  logic [AW-1:0] i_pc, i_pc_next, i_pc_target;
  logic [31:0]   o_result, o_store_data;
  logic [4:0]    o_rd;
  logic          o_reg_write, o_store, o_to_trap, o_pc_select, o_stall;
  res_src_t      o_res_src;
  logic [2:0]    o_funct3;
  logic [AW-1:0] o_pc_target;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 i_clk = ~i_clk;

  rv_alu2 #(.IADDR_SPACE_BITS(AW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
    .i_op1(i_op1), .i_op2(i_op2), .i_res(i_res), .i_ctrl(i_ctrl),
    .i_funct3(i_funct3), .i_res_src(i_res_src), .i_reg_write(i_reg_write),
    .i_rd(i_rd), .i_store(i_store), .i_inst_jal_jalr(i_inst_jal_jalr),
    .i_inst_branch(i_inst_branch), .i_pc(i_pc), .i_pc_next(i_pc_next),
    .i_pc_target(i_pc_target), .i_branch_pred(i_branch_pred),
    .i_reg_data2(i_reg_data2), .i_to_trap(i_to_trap),
    .o_result(o_result), .o_store_data(o_store_data), .o_rd(o_rd),
    .o_reg_write(o_reg_write), .o_res_src(o_res_src), .o_funct3(o_funct3),
    .o_store(o_store), .o_to_trap(o_to_trap), .o_pc_select(o_pc_select),
    .o_pc_target(o_pc_target), .o_stall(o_stall)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs change #1 after a rising edge; outputs are sampled #1 after the capturing edge.
  task automatic applyStimulus();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clearInputs();
    i_reset_n = 1'b1; i_flush = 1'b0;
    i_op1 = '0; i_op2 = '0; i_reg_data2 = '0;
    i_res = RES_ARITH; i_ctrl = CTRL_NONE; i_funct3 = 3'b000; i_res_src = SRC_ALU;
    i_reg_write = 1'b0; i_store = 1'b0; i_inst_jal_jalr = 1'b0; i_inst_branch = 1'b0;
    i_branch_pred = 1'b0; i_to_trap = 1'b0; i_rd = 5'd0;
    i_pc = 32'h0000_0010; i_pc_next = 32'h0000_0014; i_pc_target = 32'h0000_0200;
  endtask

  task automatic setAlu(input alu_res_t res, input alu_ctrl_t ctrl, input logic [31:0] a, input logic [31:0] b);
    clearInputs();
    i_res = res; i_ctrl = ctrl; i_op1 = a; i_op2 = b;
    i_reg_write = 1'b1; i_rd = 5'd7;
  endtask

  task automatic runAlu(input string tag, input alu_res_t res, input alu_ctrl_t ctrl,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] expected);
    setAlu(res, ctrl, a, b);
    applyStimulus();
    checkOutput(tag, o_result, expected);
  endtask

  task automatic runShift(input string tag, input alu_ctrl_t ctrl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expected);
    int stall_cycles;
    setAlu(RES_SHIFT, ctrl, a, b);
    applyStimulus();
    stall_cycles = 0;
`ifdef ALU_SERIAL_SHIFT_EN
    while (o_stall && stall_cycles < 40) begin
      if (stall_cycles == 0) checkOutput({tag, "_rw_gated"}, {31'b0, o_reg_write}, 32'd0);
      applyStimulus();
      stall_cycles++;
    end
    checkOutput({tag, "_stall_cycles"}, stall_cycles, {27'b0, b[4:0]});
`else
    checkOutput({tag, "_stall"}, {31'b0, o_stall}, 32'd0);
`endif
    checkOutput({tag, "_result"}, o_result, expected);
    checkOutput({tag, "_rw"}, {31'b0, o_reg_write}, 32'd1);
  endtask

  task automatic runBranch(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic pred, input logic [31:0] pc_next, input logic [31:0] target,
                           input logic exp_sel, input logic [31:0] exp_target);
    clearInputs();
    i_inst_branch = 1'b1; i_funct3 = f3; i_op1 = a; i_op2 = b;
    i_branch_pred = pred; i_pc_next = pc_next; i_pc_target = target;
    applyStimulus();
    checkOutput({tag, "_sel"}, {31'b0, o_pc_select}, {31'b0, exp_sel});
    checkOutput({tag, "_target"}, o_pc_target, exp_target);
  endtask

  initial begin
    clearInputs();
    i_reset_n = 1'b0;
    i_reg_write = 1'b1; i_store = 1'b1; i_rd = 5'd9; i_to_trap = 1'b1;
    i_inst_jal_jalr = 1'b1; i_res_src = SRC_MEM;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_rd", {27'b0, o_rd}, 32'd0);
    checkOutput("rst_rw", {31'b0, o_reg_write}, 32'd0);
    checkOutput("rst_store", {31'b0, o_store}, 32'd0);
    checkOutput("rst_trap", {31'b0, o_to_trap}, 32'd0);
    checkOutput("rst_src", {30'b0, o_res_src}, 32'd0);
    checkOutput("rst_sel", {31'b0, o_pc_select}, 32'd0);
    checkOutput("rst_stall", {31'b0, o_stall}, 32'd0);

    runAlu("add_ovf", RES_ARITH, CTRL_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
    checkOutput("add_rw", {31'b0, o_reg_write}, 32'd1);
    checkOutput("add_rd", {27'b0, o_rd}, 32'd7);
    runAlu("sub_neg", RES_ARITH, CTRL_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    runAlu("and", RES_LOGIC, CTRL_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    runAlu("or",  RES_LOGIC, CTRL_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34);
    runAlu("xor", RES_LOGIC, CTRL_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34);
    runAlu("slt",  RES_CMP, CTRL_SLT,  32'hFFFF_FFFF, 32'h1, 32'h1);
    runAlu("sltu", RES_CMP, CTRL_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0);

    runShift("sll", CTRL_SLL, 32'h1, 32'h24, 32'h10);
    runShift("srl", CTRL_SRL, 32'h8000_0000, 32'h4, 32'h0800_0000);
    runShift("sra", CTRL_SRA, 32'h8000_0000, 32'h4, 32'hF800_0000);
    runShift("sra0", CTRL_SRA, 32'h8765_4321, 32'h0, 32'h8765_4321);

    runBranch("blt",  F3_BLT,  32'hFFFF_FFFF, 32'h1, 1'b0, 32'h14, 32'h100, 1'b1, 32'h100);
    runBranch("bne",  F3_BNE,  32'd5, 32'd5, 1'b1, 32'h24, 32'h80, 1'b1, 32'h24);
    runBranch("beq",  F3_BEQ,  32'd5, 32'd5, 1'b1, 32'h24, 32'h80, 1'b0, 32'h80);
    runBranch("bgeu", F3_BGEU, 32'h1, 32'hFFFF_FFFF, 1'b0, 32'h30, 32'h90, 1'b0, 32'h30);
    runBranch("bge",  F3_BGE,  32'hFFFF_FFFF, 32'h1, 1'b1, 32'h44, 32'h90, 1'b1, 32'h44);
    runBranch("f3bad", 3'b010, 32'h0, 32'h0, 1'b1, 32'h50, 32'hA0, 1'b1, 32'h50);

    clearInputs();
    i_inst_jal_jalr = 1'b1; i_branch_pred = 1'b1; i_pc_next = 32'h8; i_pc_target = 32'h40;
    i_reg_write = 1'b1; i_rd = 5'd1; i_res_src = SRC_PC4;
    applyStimulus();
    checkOutput("jal_sel", {31'b0, o_pc_select}, 32'd0);
    checkOutput("jal_result", o_result, 32'h8);
    checkOutput("jal_target", o_pc_target, 32'h40);
    i_branch_pred = 1'b0;
    applyStimulus();
    checkOutput("jal_nopred_sel", {31'b0, o_pc_select}, 32'd1);
    i_flush = 1'b1;
    applyStimulus();
    checkOutput("jal_flush_sel", {31'b0, o_pc_select}, 32'd0);
    checkOutput("jal_flush_rw", {31'b0, o_reg_write}, 32'd0);
    checkOutput("jal_flush_rd", {27'b0, o_rd}, 32'd0);
    checkOutput("jal_flush_src", {30'b0, o_res_src}, 32'd0);

    clearInputs();
    i_branch_pred = 1'b1;
    applyStimulus();
    checkOutput("nonbr_sel", {31'b0, o_pc_select}, 32'd0);

    clearInputs();
    i_store = 1'b1; i_reg_data2 = 32'hDEAD_BEEF; i_funct3 = 3'b010; i_to_trap = 1'b1; i_res_src = SRC_MEM;
    applyStimulus();
    checkOutput("st_store", {31'b0, o_store}, 32'd1);
    checkOutput("st_data", o_store_data, 32'hDEAD_BEEF);
    checkOutput("st_f3", {29'b0, o_funct3}, 32'd2);
    checkOutput("st_trap", {31'b0, o_to_trap}, 32'd1);
    checkOutput("st_src", {30'b0, o_res_src}, 32'd1);

    setAlu(RES_SHIFT, CTRL_SRA, 32'h8000_0000, 32'd8);
    applyStimulus();
    applyStimulus();
    i_reset_n = 1'b0;
    applyStimulus();
    checkOutput("rstshift_stall", {31'b0, o_stall}, 32'd0);
    checkOutput("rstshift_rw", {31'b0, o_reg_write}, 32'd0);
    checkOutput("rstshift_sel", {31'b0, o_pc_select}, 32'd0);

    setAlu(RES_SHIFT, CTRL_SLL, 32'h1, 32'd10);
    applyStimulus();
    i_flush = 1'b1;
    applyStimulus();
    checkOutput("flushshift_stall", {31'b0, o_stall}, 32'd0);
    checkOutput("flushshift_rw", {31'b0, o_reg_write}, 32'd0);

    runAlu("post_add", RES_ARITH, CTRL_ADD, 32'd100, 32'd23, 32'd123);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
